// File: rtl/a2d_spi_resp.sv
// SPI responder for the slide-pot A2D path (ADC128S-style, 8 channels, 12-bit samples).
// Pins are oversampled in the clk domain. Each frame returns the sample for the channel
// addressed by the previous complete frame.
module a2d_spi_resp #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SS_n,
  input  logic                       SCLK,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [NUM_CH*DATA_W-1:0]   ch_vals,
  output logic [2:0]                 cur_chan,
  output logic                       frame_done,
  output logic [FRAME_BITS-1:0]      rx_cmd
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q;
  logic [1:0]            ss_q;
  logic [2:0]            sclk_q;
  logic [1:0]            mosi_q;
  logic [FRAME_BITS-1:0] tx_shf_q;
  logic [FRAME_BITS-1:0] rx_shf_q;
  logic [CW-1:0]         bit_cnt_q;
  logic                  first_rise_q;
  logic [2:0]            cur_chan_q;
  logic                  frame_done_q;
  logic [FRAME_BITS-1:0] rx_cmd_q;

  logic                  ss_n_s;
  logic                  mosi_s;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic [DATA_W-1:0]     sample_sel;

  // Synchronisers; SS_n and SCLK reset to their idle-high levels so no
  // spurious select or edge is seen coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q   <= '1;
      sclk_q <= '1;
      mosi_q <= '0;
    end else begin
      ss_q   <= {ss_q[0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  // Edge strobes and channel sample mux
  always_comb begin
    ss_n_s     = ss_q[1];
    mosi_s     = mosi_q[1];
    sclk_rise  = sclk_q[1] & ~sclk_q[2];
    sclk_fall  = ~sclk_q[1] & sclk_q[2];
    sample_sel = ch_vals[cur_chan_q*DATA_W +: DATA_W];
  end

  // Frame FSM: load on select, shift on SCLK edges, publish command at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_shf_q     <= '0;
      rx_shf_q     <= '0;
      bit_cnt_q    <= '0;
      first_rise_q <= 1'b0;
      cur_chan_q   <= '0;
      frame_done_q <= 1'b0;
      rx_cmd_q     <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Load wins over any SCLK edge seen in the same clock.
          if (!ss_n_s) begin
            tx_shf_q     <= {{(FRAME_BITS-DATA_W){1'b0}}, sample_sel};
            bit_cnt_q    <= '0;
            first_rise_q <= 1'b0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == LAST_CNT) begin
            rx_cmd_q     <= rx_shf_q;
            cur_chan_q   <= rx_shf_q[13:11];
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (ss_n_s) begin
            state_q <= IDLE;
          end else begin
            if (sclk_rise) begin
              rx_shf_q     <= {rx_shf_q[FRAME_BITS-2:0], mosi_s};
              bit_cnt_q    <= bit_cnt_q + 1'b1;
              first_rise_q <= 1'b1;
            end
            // The leading fall from the idle-high SCLK precedes any rise and is skipped.
            if (sclk_fall && first_rise_q) begin
              tx_shf_q <= {tx_shf_q[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (ss_n_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO       = (state_q == SHIFT) ? tx_shf_q[FRAME_BITS-1] : 1'b0;
  assign cur_chan   = cur_chan_q;
  assign frame_done = frame_done_q;
  assign rx_cmd     = rx_cmd_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: directed scenarios followed by randomized
// frames, checked against a channel-table / last-command reference model.
module tb_a2d_spi_resp;

  localparam int H = 6;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] ch_vals = '0;
  logic [2:0]  cur_chan;
  logic        frame_done;
  logic [15:0] rx_cmd;

  a2d_spi_resp #(.NUM_CH(8), .DATA_W(12), .FRAME_BITS(16)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_vals(ch_vals), .cur_chan(cur_chan), .frame_done(frame_done), .rx_cmd(rx_cmd)
  );

  always #10 clk = ~clk;

  // Reference model state
  logic [11:0] vals[8];
  int unsigned mc = 0;
  logic [15:0] rxe = '0;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;

  always @(negedge clk) if (!rst && frame_done) fd_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_vals();
    for (int i = 0; i < 8; i++) ch_vals[i*12 +: 12] = vals[i];
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 8; i++) vals[i] = 12'($urandom);
    drive_vals();
  endtask

  // mode 0: normal / abort by SS_n after nbits; 2: change ch_vals after load; 3: reset after nbits
  task automatic do_frame(input logic [15:0] cmd, input int nbits, input int mode, input int gap);
    logic [15:0] got;
    logic [15:0] exp;
    int fd0;
    exp = {4'b0, vals[mc]};
    fd0 = fd_cnt;
    got = '0;
    @(negedge clk) SS_n = 1'b0;
    repeat (5) @(negedge clk);
    if (mode == 2) begin
      rand_vals();
      vals[mc] = 12'hFFF;
      drive_vals();
    end
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      repeat (H) @(negedge clk);
      got[15-i] = MISO;
      SCLK = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (mode == 3) begin
      #3 rst = 1'b1;
      #1;
      check_val("rst_mid_miso", 32'(MISO), 0);
      check_val("rst_mid_chan", 32'(cur_chan), 0);
      check_val("rst_mid_rxcmd", 32'(rx_cmd), 0);
      check_val("rst_mid_fdone", 32'(frame_done), 0);
      SS_n = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      mc = 0;
      rxe = '0;
      repeat (4) @(negedge clk);
      return;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (gap) @(negedge clk);
    if (nbits == 16) begin
      check_val("miso_word", 32'(got), 32'(exp));
      mc = int'(cmd[13:11]);
      rxe = cmd;
      check_val("frame_done_cnt", 32'(fd_cnt - fd0), 1);
    end else begin
      check_val("abort_no_fdone", 32'(fd_cnt - fd0), 0);
    end
    check_val("cur_chan", 32'(cur_chan), 32'(mc));
    check_val("rx_cmd", 32'(rx_cmd), 32'(rxe));
  endtask

  initial begin
    logic [15:0] c;
    int pick;
    for (int i = 0; i < 8; i++) vals[i] = 12'(16'h0100 + i);
    drive_vals();

    // Reset state
    repeat (4) @(negedge clk);
    check_val("reset_miso", 32'(MISO), 0);
    check_val("reset_chan", 32'(cur_chan), 0);
    check_val("reset_fdone", 32'(frame_done), 0);
    check_val("reset_rxcmd", 32'(rx_cmd), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Directed scenarios
    vals[0] = 12'hA5C;
    vals[3] = 12'h123;
    drive_vals();
    do_frame(16'h1800, 16, 0, 6);  // returns ch0, selects ch3
    do_frame(16'h0000, 16, 2, 6);  // returns ch3 despite mid-frame change, selects ch0
    do_frame(16'h2800, 16, 0, 6);  // selects ch5
    do_frame(16'h3800, 9, 0, 6);   // aborted, selection stays ch5
    do_frame(16'h0000, 16, 0, 6);  // returns ch5
    do_frame(16'h3800, 5, 3, 6);   // reset mid-frame
    do_frame(16'h1000, 16, 0, 6);  // returns ch0
    do_frame(16'h0800, 16, 0, 1);  // minimal gap before next frame
    do_frame(16'h7FFF, 16, 0, 1);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      rand_vals();
      c = 16'($urandom);
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      do_frame(c, int'($urandom_range(1, 15)), 0, int'($urandom_range(1, 4)));
      else if (pick == 1) do_frame(c, 16, 2, int'($urandom_range(1, 4)));
      else if (pick == 2) do_frame(c, int'($urandom_range(1, 15)), 3, 4);
      else                do_frame(c, 16, 0, int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
